// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the async FIFO.
// Synchronizes the write-domain Gray pointer, keeps the read pointer in binary and Gray form,
// issues memory read requests and presents a first-word-fall-through output register with a
// valid/ready handshake.
module fifo_rd_ctrl #(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 16,
    parameter  int AE_THRESH = 2,
    localparam int ADDR      = $clog2(DEPTH)
) (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic [ADDR:0]    wptr_gray,
    output logic [ADDR:0]    rptr_gray,
    output logic [ADDR-1:0]  raddr,
    output logic             rd_rq,
    output logic             empty,
    input  logic [WIDTH-1:0] rdata_mem,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [ADDR:0]    rd_count,
    output logic             almost_empty
);

    localparam logic [ADDR:0] AE_LIM = AE_THRESH[ADDR:0];

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_FULL = 1'b1
    } out_state_t;

    out_state_t    state;
    logic [ADDR:0] rbin;
    logic [ADDR:0] wq1;
    logic [ADDR:0] wq2;
    logic [ADDR:0] rbin_next;
    logic [ADDR:0] rgray_next;
    logic [ADDR:0] wbin_sync;
    logic [ADDR:0] count_next;
    logic          pop;

    function automatic logic [ADDR:0] gray2bin(input logic [ADDR:0] g);
        logic [ADDR:0] b;
        b = '0;
        b[ADDR] = g[ADDR];
        for (int unsigned i = 0; i < ADDR; i++) begin
            b[ADDR-1-i] = b[ADDR-i] ^ g[ADDR-1-i];
        end
        return b;
    endfunction

    assign dout_valid = (state == OUT_FULL);
    assign raddr      = rbin[ADDR-1:0];
    assign rd_rq      = pop;

    // Pop decision and next-pointer / next-count arithmetic
    always_comb begin
        pop        = !r_rst && !empty && (!dout_valid || dout_ready);
        rbin_next  = rbin + {{ADDR{1'b0}}, pop};
        rgray_next = rbin_next ^ (rbin_next >> 1);
        wbin_sync  = gray2bin(wq2);
        count_next = wbin_sync - rbin_next;
    end

    // Write-pointer synchronizer, read pointer, empty/count/almost-empty flags
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            wq1          <= '0;
            wq2          <= '0;
            rbin         <= '0;
            rptr_gray    <= '0;
            empty        <= 1'b1;
            rd_count     <= '0;
            almost_empty <= 1'b1;
        end else begin
            wq1          <= wptr_gray;
            wq2          <= wq1;
            rbin         <= rbin_next;
            rptr_gray    <= rgray_next;
            empty        <= (rgray_next == wq2);
            rd_count     <= count_next;
            almost_empty <= (count_next <= AE_LIM);
        end
    end

    // Output register FSM: load on pop, hold under backpressure, drain to idle
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state <= OUT_IDLE;
            dout  <= '0;
        end else begin
            case (state)
                OUT_IDLE: begin
                    if (pop) begin
                        dout  <= rdata_mem;
                        state <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (dout_ready) begin
                        if (pop) begin
                            dout <= rdata_mem;
                        end else begin
                            state <= OUT_IDLE;
                        end
                    end
                end
                default: state <= OUT_IDLE;
            endcase
        end
    end

endmodule
